// File: rtl/cpu_register_file.sv
// cpu_register_file: 32 x DATA_W general-purpose register file.
// Two asynchronous read ports and one synchronous write port. Reads of PC_IDX
// return the external r15 (PC) input; writes to PC_IDX are dropped.
// Optional macro REGFILE_WR_BYPASS_EN: forwards di to a read port whose address
// matches an active write in the same cycle (the PC alias still wins).
module cpu_register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned PC_IDX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              REG_WR,
  input  logic [ADDR_W-1:0] dirA,
  input  logic [ADDR_W-1:0] dirB,
  input  logic [ADDR_W-1:0] dirWR,
  input  logic [DATA_W-1:0] di,
  input  logic [DATA_W-1:0] r15,
  output logic [DATA_W-1:0] doA,
  output logic [DATA_W-1:0] doB
);

  localparam int unsigned       DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_en;

  // A write lands only when enabled and not aimed at the PC alias.
  assign wr_en = REG_WR && (dirWR != PC_ADDR);

  // Next-state contents: copy of current contents with the addressed word replaced.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[dirWR] = di;
    end
  end

  // Storage update; synchronous reset clears every register and discards the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read port A: stored value, optional write forwarding, PC alias has final say.
  always_comb begin
    doA = mem_q[dirA];
`ifdef REGFILE_WR_BYPASS_EN
    if (!rst && wr_en && (dirA == dirWR)) begin
      doA = di;
    end
`endif
    if (dirA == PC_ADDR) begin
      doA = r15;
    end
  end

  // Read port B: same selection as port A.
  always_comb begin
    doB = mem_q[dirB];
`ifdef REGFILE_WR_BYPASS_EN
    if (!rst && wr_en && (dirB == dirWR)) begin
      doB = di;
    end
`endif
    if (dirB == PC_ADDR) begin
      doB = r15;
    end
  end

endmodule

// File: tb/tb_cpu_register_file.sv
// tb_cpu_register_file: directed scenarios followed by randomized traffic,
// checked against an array-based reference model of the register file.
// Honours REGFILE_WR_BYPASS_EN when the design is built with it.
module tb_cpu_register_file;

  logic        clk;
  logic        rst;
  logic        REG_WR;
  logic [4:0]  dirA;
  logic [4:0]  dirB;
  logic [4:0]  dirWR;
  logic [31:0] di;
  logic [31:0] r15;
  logic [31:0] doA;
  logic [31:0] doB;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [31:0] model [32];

  cpu_register_file #(
    .DATA_W(32),
    .ADDR_W(5),
    .PC_IDX(15)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .REG_WR(REG_WR),
    .dirA  (dirA),
    .dirB  (dirB),
    .dirWR (dirWR),
    .di    (di),
    .r15   (r15),
    .doA   (doA),
    .doB   (doB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // What a read of addr should return right now, from the model and current inputs.
  function automatic logic [31:0] expect_rd(input logic [4:0] addr);
    if (int'(addr) == 15) return r15;
`ifdef REGFILE_WR_BYPASS_EN
    if (!rst && REG_WR && int'(dirWR) != 15 && addr == dirWR) return di;
`endif
    return model[addr];
  endfunction

  // One rising edge: apply the storage rules to the model, then settle.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) model[k] = '0;
    end else if (REG_WR && int'(dirWR) != 15) begin
      model[dirWR] = di;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    REG_WR = 1'b1; dirWR = a; di = d;
    step();
    REG_WR = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; REG_WR = 1'b0; dirA = '0; dirB = '0; dirWR = '0; di = '0; r15 = '0;

    // Reset
    step();
    rst = 1'b0; REG_WR = 1'b0; dirA = 5'd1; dirB = 5'd4; r15 = '0;
    #1;
    check("reset_doA", doA, 32'd0);
    check("reset_doB", doB, 32'd0);
    for (int k = 0; k < 32; k++) begin
      dirA = 5'(k);
      #1;
      check("reset_all", doA, 32'd0);
    end

    // Write / readback
    write_reg(5'd7, 32'd21);
    write_reg(5'd10, 32'd55);
    dirA = 5'd7; dirB = 5'd10;
    #1;
    check("wr_rd_A7", doA, 32'd21);
    check("wr_rd_B10", doB, 32'd55);

    // Write disabled
    REG_WR = 1'b0; dirWR = 5'd8; di = 32'd197;
    step();
    dirA = 5'd8;
    #1;
    check("wr_dis", doA, 32'd0);

    // PC alias
    r15 = 32'd8; dirB = 5'd15;
    #1;
    check("pc_alias", doB, 32'd8);
    r15 = 32'd12;
    #1;
    check("pc_alias_comb", doB, 32'd12);
    write_reg(5'd15, 32'd99);
    #1;
    check("pc_wr_ignored", doB, 32'd12);
    dirA = 5'd15;
    #1;
    check("pc_alias_A", doA, 32'd12);

    // Reset priority and reset clearing live data
    write_reg(5'd20, 32'd77);
    dirA = 5'd20;
    #1;
    check("pre_rst_r20", doA, 32'd77);
    rst = 1'b1; REG_WR = 1'b1; dirWR = 5'd3; di = 32'd5;
    step();
    rst = 1'b0; REG_WR = 1'b0; dirA = 5'd3; dirB = 5'd20;
    #1;
    check("rst_prio_r3", doA, 32'd0);
    check("rst_clr_r20", doB, 32'd0);
    dirA = 5'd7;
    #1;
    check("rst_clr_r7", doA, 32'd0);

    // Same address on both ports
    write_reg(5'd9, 32'hdead_beef);
    dirA = 5'd9; dirB = 5'd9;
    #1;
    check("same_A", doA, 32'hdead_beef);
    check("same_B", doB, 32'hdead_beef);

    // Read-during-write
    write_reg(5'd5, 32'd1);
    REG_WR = 1'b1; dirWR = 5'd5; di = 32'd2; dirA = 5'd5; dirB = 5'd0;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    check("rdw_before", doA, 32'd2);
`else
    check("rdw_before", doA, 32'd1);
`endif
    step();
    REG_WR = 1'b0;
    #1;
    check("rdw_after", doA, 32'd2);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 39) == 0);
      REG_WR = $urandom_range(0, 2) != 0;
      dirWR  = ($urandom_range(0, 9) == 0) ? 5'd15 : 5'($urandom_range(0, 31));
      di     = $urandom;
      r15    = $urandom;
      case ($urandom_range(0, 3))
        0:       dirA = dirWR;
        1:       dirA = 5'd15;
        default: dirA = 5'($urandom_range(0, 31));
      endcase
      dirB = ($urandom_range(0, 3) == 0) ? dirWR : 5'($urandom_range(0, 31));
      #1;
      check("rnd_pre_A", doA, expect_rd(dirA));
      check("rnd_pre_B", doB, expect_rd(dirB));
      step();
      check("rnd_post_A", doA, expect_rd(dirA));
      check("rnd_post_B", doB, expect_rd(dirB));
    end

    // Final sweep of every register
    rst = 1'b0; REG_WR = 1'b0;
    for (int k = 0; k < 32; k++) begin
      dirA = 5'(k);
      dirB = 5'(31 - k);
      #1;
      check("sweep_A", doA, expect_rd(dirA));
      check("sweep_B", doB, expect_rd(dirB));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
